// File: rtl/edge_pkg.sv
// Shared types and constants for the multi-channel edge detector.
package edge_pkg;

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      PEND_HIGH = 2'd1,
      HIGH      = 2'd2,
      PEND_LOW  = 2'd3
   } edge_state_t;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   function automatic logic rise_enabled(input logic [1:0] m);
      return (m == MODE_RISE) || (m == MODE_BOTH);
   endfunction

   function automatic logic fall_enabled(input logic [1:0] m);
      return (m == MODE_FALL) || (m == MODE_BOTH);
   endfunction

endpackage

// File: rtl/edge_channel.sv
// One channel: synchroniser, debounce FSM, gated rise/fall ticks and sticky flag.
//
// state     | meaning
// LOW       | filtered level 0, input agrees
// PEND_HIGH | filtered level 0, counting consecutive 1 samples
// HIGH      | filtered level 1, input agrees
// PEND_LOW  | filtered level 1, counting consecutive 0 samples
module edge_channel
   import edge_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       level,
   input  logic [1:0] mode,
   input  logic       clr,
   output logic       level_filt,
   output logic       rise_tick,
   output logic       fall_tick,
   output logic       event_flag,
   output logic       flag_next
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sample;
   logic [CW-1:0]          cnt;
   edge_state_t            state;
   logic                   rise_en;
   logic                   fall_en;

   assign sample  = sync_q[SYNC_STAGES-1];
   assign rise_en = rise_enabled(mode);
   assign fall_en = fall_enabled(mode);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], level};
      end
   end

   // mode is sampled on the accepting edge, so a mode change gates that same event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= LOW;
         cnt        <= '0;
         level_filt <= 1'b0;
         rise_tick  <= 1'b0;
         fall_tick  <= 1'b0;
      end else begin
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
         case (state)
            LOW: begin
               if (sample) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state      <= HIGH;
                     level_filt <= 1'b1;
                     rise_tick  <= rise_en;
                  end else begin
                     state <= PEND_HIGH;
                     cnt   <= CNT_ONE;
                  end
               end
            end
            PEND_HIGH: begin
               if (!sample) begin
                  state <= LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state      <= HIGH;
                  cnt        <= '0;
                  level_filt <= 1'b1;
                  rise_tick  <= rise_en;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            HIGH: begin
               if (!sample) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state      <= LOW;
                     level_filt <= 1'b0;
                     fall_tick  <= fall_en;
                  end else begin
                     state <= PEND_LOW;
                     cnt   <= CNT_ONE;
                  end
               end
            end
            PEND_LOW: begin
               if (sample) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state      <= LOW;
                  cnt        <= '0;
                  level_filt <= 1'b0;
                  fall_tick  <= fall_en;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

   // a tick arriving together with clr keeps the flag set
   assign flag_next = rise_tick | fall_tick | (event_flag & ~clr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         event_flag <= 1'b0;
      end else begin
         event_flag <= flag_next;
      end
   end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector with sticky flags and an interrupt summary.
module multi_edge_detector
   import edge_pkg::*;
#(
   parameter int CHANNELS        = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CHANNELS-1:0]   level,
   input  logic [2*CHANNELS-1:0] mode,
   input  logic [CHANNELS-1:0]   clr,
   output logic [CHANNELS-1:0]   level_filt,
   output logic [CHANNELS-1:0]   rise_tick,
   output logic [CHANNELS-1:0]   fall_tick,
   output logic [CHANNELS-1:0]   event_flag,
   output logic                  any_event
);

   logic [CHANNELS-1:0] flag_next;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      edge_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .level     (level[i]),
         .mode      (mode[2*i +: 2]),
         .clr       (clr[i]),
         .level_filt(level_filt[i]),
         .rise_tick (rise_tick[i]),
         .fall_tick (fall_tick[i]),
         .event_flag(event_flag[i]),
         .flag_next (flag_next[i])
      );
   end

   // built from next-state flags so it moves on the same edge as event_flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_event <= 1'b0;
      end else begin
         any_event <= |flag_next;
      end
   end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench: stimulus queues expected values by cycle, a negedge monitor compares.
module tb_multi_edge_detector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  level;
   logic [15:0] mode;
   logic [7:0]  clr;
   logic [7:0]  level_filt;
   logic [7:0]  rise_tick;
   logic [7:0]  fall_tick;
   logic [7:0]  event_flag;
   logic        any_event;

   multi_edge_detector #(
      .CHANNELS(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .level     (level),
      .mode      (mode),
      .clr       (clr),
      .level_filt(level_filt),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick),
      .event_flag(event_flag),
      .any_event (any_event)
   );

   always #5 clk = ~clk;

   localparam int S_RISE = 0, S_FALL = 1, S_FLAG = 2, S_FILT = 3, S_ANY = 4;

   typedef struct {
      int         cyc;
      int         sig;
      logic [7:0] mask;
      logic [7:0] val;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   edge_n = 0;
   int   n_vec  = 0;
   int   n_err  = 0;

   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic logic [7:0] pick(input int s);
      case (s)
         S_RISE:  return rise_tick;
         S_FALL:  return fall_tick;
         S_FLAG:  return event_flag;
         S_FILT:  return level_filt;
         default: return {7'b0, any_event};
      endcase
   endfunction

   // monitor: pops every entry due this cycle; also flags any tick nobody expected
   always @(negedge clk) begin
      logic [7:0] allow_r, allow_f, act;
      allow_r = '0;
      allow_f = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == edge_n) begin
            act = pick(sb[i].sig) & sb[i].mask;
            n_vec++;
            if (act !== sb[i].val) begin
               n_err++;
               $display("FAIL %s @cyc %0d: got %02h, want %02h (mask %02h)",
                        sb[i].name, edge_n, act, sb[i].val, sb[i].mask);
            end
            if (sb[i].sig == S_RISE) allow_r |= sb[i].mask;
            if (sb[i].sig == S_FALL) allow_f |= sb[i].mask;
            sb.delete(i);
         end else if (sb[i].cyc < edge_n) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: stale entry for cyc %0d at cyc %0d", sb[i].name, sb[i].cyc, edge_n);
            sb.delete(i);
         end
      end
      if ((rise_tick & ~allow_r) != 8'h00) begin
         n_vec++;
         n_err++;
         $display("FAIL unexpected_rise @cyc %0d: got %02h, want 00 outside %02h", edge_n, rise_tick, allow_r);
      end
      if ((fall_tick & ~allow_f) != 8'h00) begin
         n_vec++;
         n_err++;
         $display("FAIL unexpected_fall @cyc %0d: got %02h, want 00 outside %02h", edge_n, fall_tick, allow_f);
      end
   end

   task automatic chk(input int cyc, input int sig, input logic [7:0] mask,
                      input logic [7:0] val, input string name);
      exp_t e;
      e.cyc = cyc; e.sig = sig; e.mask = mask; e.val = val; e.name = name;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // level driven just after edge e: tick and level_filt update on edge e+6
   task automatic edge_chk(input int e, input logic [7:0] chm, input bit rise,
                           input logic [7:0] emit, input string name);
      int s;
      s = rise ? S_RISE : S_FALL;
      chk(e + 5, s, chm, 8'h00, {name, "_early"});
      chk(e + 6, s, chm, emit, name);
      chk(e + 7, s, chm, 8'h00, {name, "_one_cycle"});
      chk(e + 5, S_FILT, chm, rise ? 8'h00 : chm, {name, "_filt_pre"});
      chk(e + 6, S_FILT, chm, rise ? chm : 8'h00, {name, "_filt"});
   endtask

   task automatic clear_all(input string name);
      clr = 8'hFF;
      chk(edge_n + 1, S_FLAG, 8'hFF, 8'h00, {name, "_flags_clr"});
      chk(edge_n + 1, S_ANY, 8'h01, 8'h00, {name, "_any_clr"});
      step(1);
      clr = 8'h00;
   endtask

   initial begin
      int e, e2, r;
      rst_n = 1'b0;
      level = 8'h00;
      mode  = 16'hFFFF;
      clr   = 8'h00;
      step(2);
      chk(edge_n, S_RISE, 8'hFF, 8'h00, "rst_rise");
      chk(edge_n, S_FALL, 8'hFF, 8'h00, "rst_fall");
      chk(edge_n, S_FLAG, 8'hFF, 8'h00, "rst_flag");
      chk(edge_n, S_FILT, 8'hFF, 8'h00, "rst_filt");
      chk(edge_n, S_ANY,  8'h01, 8'h00, "rst_any");
      step(1);
      rst_n = 1'b1;
      step(2);

      // basic rise and fall on ch0
      e = edge_n;
      level[0] = 1'b1;
      edge_chk(e, 8'h01, 1, 8'h01, "ch0_rise");
      chk(e + 6, S_FLAG, 8'h01, 8'h00, "ch0_flag_pre");
      chk(e + 7, S_FLAG, 8'h01, 8'h01, "ch0_flag");
      chk(e + 6, S_ANY, 8'h01, 8'h00, "ch0_any_pre");
      chk(e + 7, S_ANY, 8'h01, 8'h01, "ch0_any");
      step(10);
      e = edge_n;
      level[0] = 1'b0;
      edge_chk(e, 8'h01, 0, 8'h01, "ch0_fall");
      step(8);
      clear_all("t1");

      // glitch of 3 cycles rejected, then 4-cycle pulse accepted both ways
      e = edge_n;
      level[1] = 1'b1;
      chk(e + 6, S_RISE, 8'h02, 8'h00, "glitch_no_tick");
      chk(e + 7, S_RISE, 8'h02, 8'h00, "glitch_no_tick2");
      chk(e + 6, S_FILT, 8'h02, 8'h00, "glitch_filt");
      chk(e + 8, S_FILT, 8'h02, 8'h00, "glitch_filt2");
      step(3);
      level[1] = 1'b0;
      step(8);
      e = edge_n;
      level[1] = 1'b1;
      edge_chk(e, 8'h02, 1, 8'h02, "d4_rise");
      step(4);
      e2 = edge_n;
      level[1] = 1'b0;
      edge_chk(e2, 8'h02, 0, 8'h02, "d4_fall");
      chk(e2 + 7, S_FLAG, 8'hFF, 8'h02, "d4_flag");
      step(8);
      clear_all("t2");

      // ch1 rise-only mode
      mode = 16'hFFF7;
      e = edge_n;
      level[1] = 1'b1;
      edge_chk(e, 8'h02, 1, 8'h02, "gate_rise");
      step(6);
      e2 = edge_n;
      level[1] = 1'b0;
      edge_chk(e2, 8'h02, 0, 8'h00, "gate_no_fall");
      chk(e2 + 7, S_FLAG, 8'hFF, 8'h02, "gate_one_flag");
      step(8);
      clear_all("t3a");

      // ch1 off: filtering continues, nothing emitted
      mode = 16'hFFF3;
      e = edge_n;
      level[1] = 1'b1;
      edge_chk(e, 8'h02, 1, 8'h00, "off_rise");
      step(6);
      e2 = edge_n;
      level[1] = 1'b0;
      edge_chk(e2, 8'h02, 0, 8'h00, "off_fall");
      chk(e2 + 7, S_FLAG, 8'hFF, 8'h00, "off_no_flag");
      chk(e2 + 7, S_ANY, 8'h01, 8'h00, "off_no_any");
      step(8);
      mode = 16'hFFFF;

      // clear coinciding with flag set loses; clear a cycle later wins
      e = edge_n;
      level[2] = 1'b1;
      edge_chk(e, 8'h04, 1, 8'h04, "clr_rise");
      step(6);
      clr = 8'h04;
      chk(e + 7, S_FLAG, 8'h04, 8'h04, "clr_race_set_wins");
      chk(e + 7, S_ANY, 8'h01, 8'h01, "clr_race_any");
      step(1);
      chk(e + 8, S_FLAG, 8'hFF, 8'h00, "clr_next");
      chk(e + 8, S_ANY, 8'h01, 8'h00, "clr_next_any");
      step(1);
      clr = 8'h00;
      e = edge_n;
      level[2] = 1'b0;
      edge_chk(e, 8'h04, 0, 8'h04, "clr_fall");
      step(8);
      clear_all("t4");

      // all channels at once
      e = edge_n;
      level = 8'hFF;
      edge_chk(e, 8'hFF, 1, 8'hFF, "multi_rise");
      chk(e + 7, S_FLAG, 8'hFF, 8'hFF, "multi_flags");
      step(8);
      e = edge_n;
      level = 8'h00;
      edge_chk(e, 8'hFF, 0, 8'hFF, "multi_fall");
      step(8);
      clear_all("t5");

      // reset during PEND_HIGH on ch0 while ch5 is already high and flagged
      e = edge_n;
      level = 8'h20;
      edge_chk(e, 8'h20, 1, 8'h20, "pre_rst_rise");
      chk(e + 7, S_FLAG, 8'hFF, 8'h20, "pre_rst_flag");
      step(8);
      level = 8'h21;
      step(4);
      rst_n = 1'b0;
      chk(edge_n, S_FILT, 8'hFF, 8'h00, "async_rst_filt");
      chk(edge_n, S_FLAG, 8'hFF, 8'h00, "async_rst_flag");
      chk(edge_n, S_ANY, 8'h01, 8'h00, "async_rst_any");
      step(2);
      rst_n = 1'b1;
      r = edge_n;
      edge_chk(r, 8'h21, 1, 8'h21, "post_rst_rise");
      chk(r + 7, S_FLAG, 8'hFF, 8'h21, "post_rst_flags");
      step(10);

      for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
      while (sb.size() > 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: never checked, cyc %0d", sb[0].name, sb[0].cyc);
         sb.delete(0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised multi-channel edge detector: each channel synchronises an asynchronous level input, debounces it, and emits registered one-cycle rise and fall ticks gated by a per-channel runtime mode. Sticky per-channel event flags with clear and a combined interrupt summary let slower logic poll or take an interrupt. The block sits between raw pins or slow status levels and control FSMs that consume single-cycle ticks.

## Interface
- CHANNELS, 8, number of independent channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- DEBOUNCE_CYCLES, 4, consecutive differing samples required to accept a level change (≥1)
- clk  input  1  single clock; all logic on posedge
- rst_n  input  1  asynchronous, active-low reset
- level  input  CHANNELS  raw asynchronous levels
- mode  input  2*CHANNELS  per channel {mode[2i+1], mode[2i]}: 00 off, 01 rise, 10 fall, 11 both
- clr  input  CHANNELS  clears event_flag[i] (single-cycle pulse, level-tolerant)
- level_filt  output  CHANNELS  debounced level, registered
- rise_tick  output  CHANNELS  one-cycle pulse on accepted 0→1, if mode[2i] set
- fall_tick  output  CHANNELS  one-cycle pulse on accepted 1→0, if mode[2i+1] set
- event_flag  output  CHANNELS  sticky, set by any emitted tick
- any_event  output  1  registered OR of event_flag

## Operation
- Per-channel FSM: LOW, PEND_HIGH, HIGH, PEND_LOW. level_filt = 1 in HIGH and PEND_LOW.
- The debounce counter (width max(1, $clog2(DEBOUNCE_CYCLES))) counts consecutive synchronised samples that differ from level_filt.
- LOW: sample=1 → if DEBOUNCE_CYCLES==1, go to HIGH with tick; else go to PEND_HIGH with cnt=1.
- PEND_HIGH: sample=0 → LOW, cnt=0, no tick (glitch rejected). Sample=1 and cnt==DEBOUNCE_CYCLES-1 → HIGH, cnt=0, rise event. Otherwise cnt++.
- HIGH and PEND_LOW: symmetric, producing a fall event.
- Rise event → rise_tick[i]=1 for exactly one cycle iff mode[2i]=1. Fall event → fall_tick[i]=1 iff mode[2i+1]=1.
- Filtering always runs. mode only gates ticks and flags. A mode change takes effect for events accepted on the same edge.
- event_flag[i]: set on the cycle after an emitted tick; cleared by clr[i]. Simultaneous set and clear → set wins.
- any_event is registered from the next-state event_flag vector, so it changes on the same edge as event_flag.
- Channels are fully independent. Simultaneous events on multiple channels all produce ticks.

## Timing
- Reset (rst_n=0, asynchronous): all sync flops 0, every FSM in LOW, cnt 0, level_filt 0, rise_tick 0, fall_tick 0, event_flag 0, any_event 0.
- Reset is effective mid-debounce: a pending change is discarded.
- A channel held high through reset release produces a rise event S+D-1 cycles after release. This behaviour is required.
- Latency: with level change captured at edge k, level_filt and the tick update at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. Defaults: 5 cycles.
- event_flag and any_event update one edge after the tick.
- Minimum accepted pulse width: DEBOUNCE_CYCLES cycles of the synchronised signal. Shorter pulses produce no tick and no level_filt change.
- Back-to-back opposite edges are accepted, each needing its own full debounce window. Minimum spacing between ticks on one channel is DEBOUNCE_CYCLES cycles.
- The counter never wraps; it resets to 0 on accept or on reject.

## Structure
- Package edge_pkg holds:
  - the state typedef {LOW, PEND_HIGH, HIGH, PEND_LOW}
  - the mode constants MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH
- Sub-module edge_channel holds the synchroniser, FSM, counter, tick and flag logic for one channel, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES.
- The top level instantiates edge_channel in a generate loop and forms any_event.

## Test plan
- Reset release, level=0, mode=all 11: drive level[0] 0→1 held 10 cycles → rise_tick[0] high for exactly one cycle, 5 cycles after capture; event_flag[0]=1 one cycle later; any_event=1.
- Glitch rejection: level[1] high for 3 cycles (D=4) → no tick, level_filt[1] stays 0. Then high for 4 cycles → rise tick, then after the fall a fall tick 4 cycles later.
- Mode gating: mode[3:2]=01 with a full pulse on ch1 → rise_tick only, no fall_tick, one flag set. mode=00 → level_filt toggles, no ticks, no flags.
- Flag clear race: assert clr[2] on the same cycle the ch2 flag sets → flag stays 1. clr on the next cycle → flag 0, any_event 0 if no others set.
- Multi-channel: all 8 channels rise on the same cycle → all 8 rise_ticks on one cycle, event_flag=8'hFF.
- Reset mid-operation: level[0] held high, rst_n pulsed low during PEND_HIGH → outputs go to 0 immediately; after release, rise_tick[0] fires 5 cycles later.
